rv16_fu_result_collector: RTL and testbench

//  Return path of the rv16 execute stage: collects results from the seven functional units
//  (ADD, SUB, MUL, DIV, XOR, AND, OR) fed by the rs1/rs2 operand demuxes.

---
 rtl/rv16_pkg.sv | 28 ++
 rtl/rv16_rr_arbiter.sv | 42 ++++
 rtl/rv16_fu_result_collector.sv | 91 +++++++++
 tb/tb_rv16_fu_result_collector.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv16_pkg.sv
// rv16_pkg: shared types and constants for the rv16 execute-stage result return path
//    RV16_RESULT_FLAGS_EN adds zero/neg flags to each writeback entry
package rv16_pkg;
   localparam int RV16_DATA     = 16;
   localparam int RV16_REG_ADDR = 3;
   localparam int RV16_NUM_FU   = 7;
   localparam int RV16_OPCODE   = 4;

   typedef enum logic [RV16_OPCODE-1:0] {
      ADD = 4'd0,
      SUB = 4'd1,
      MUL = 4'd2,
      DIV = 4'd3,
      XOR = 4'd4,
      AND = 4'd5,
      OR  = 4'd6
   } rv16_opcode_e;

   typedef struct packed {
      logic [RV16_DATA-1:0]     data;
      logic [RV16_REG_ADDR-1:0] rd;
      rv16_opcode_e             opcode;
`ifdef RV16_RESULT_FLAGS_EN
      logic                     zero;
      logic                     neg;
`endif
   } rv16_wb_entry_t;
endpackage

// File: rtl/rv16_rr_arbiter.sv
// rv16_rr_arbiter: round-robin one-hot arbiter with rotating priority pointer
//    clk, rst_n : clock, async active-low reset (pointer -> 0)
//    i_req      : request per requester
//    i_en       : grant permitted this cycle
//    o_grant    : one-hot grant (zero when disabled or no request)
//    o_idx      : index of the winning requester (valid when any request)
module rv16_rr_arbiter
   import rv16_pkg::*;
#(
   parameter  int N  = RV16_NUM_FU,
   localparam int PW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  i_req,
   input  logic          i_en,
   output logic [N-1:0]  o_grant,
   output logic [PW-1:0] o_idx
);
   logic [PW-1:0] r_ptr;
   logic          w_found;

   // Scan upward from the pointer, wrapping at N-1; first requester wins.
   always_comb begin
      o_idx   = r_ptr;
      w_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!w_found && i_req[PW'((int'(r_ptr) + k) % N)]) begin
            w_found = 1'b1;
            o_idx   = PW'((int'(r_ptr) + k) % N);
         end
      end
      o_grant = (i_en && w_found) ? {{(N-1){1'b0}}, 1'b1} << o_idx : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_ptr <= '0;
      else if (i_en && w_found)
         r_ptr <= (o_idx == PW'(N - 1)) ? '0 : o_idx + 1'b1;
   end
endmodule

// File: rtl/rv16_fu_result_collector.sv
// rv16_fu_result_collector: collects functional-unit results round-robin into a writeback FIFO
//    clk, rst_n             : clock, async active-low reset (drops all buffered results)
//    i_fu_valid/o_fu_ready  : per-unit valid/ready handshake, ready is one-hot grant
//    i_fu_result, i_fu_rd   : per-unit result and destination register slices
//    o_wb_valid/i_wb_ready  : FIFO head handshake towards writeback
//    o_wb_data/rd/opcode    : head entry; opcode is the source unit index
//    o_fifo_count           : FIFO occupancy 0..DEPTH
//    o_wb_zero/o_wb_neg     : head flags, present only with RV16_RESULT_FLAGS_EN
module rv16_fu_result_collector
   import rv16_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [RV16_NUM_FU-1:0]             i_fu_valid,
   input  logic [RV16_NUM_FU*RV16_DATA-1:0]   i_fu_result,
   input  logic [RV16_NUM_FU*RV16_REG_ADDR-1:0] i_fu_rd,
   output logic [RV16_NUM_FU-1:0]             o_fu_ready,
   output logic                               o_wb_valid,
   input  logic                               i_wb_ready,
   output logic [RV16_DATA-1:0]               o_wb_data,
   output logic [RV16_REG_ADDR-1:0]           o_wb_rd,
   output logic [RV16_OPCODE-1:0]             o_wb_opcode,
   output logic [AW:0]                        o_fifo_count
`ifdef RV16_RESULT_FLAGS_EN
   ,
   output logic                               o_wb_zero,
   output logic                               o_wb_neg
`endif
);
   rv16_wb_entry_t                 r_mem [DEPTH];
   logic [AW-1:0]                  r_wr, r_rd;
   logic [AW:0]                    r_count;
   logic                           w_pop, w_push, w_en;
   logic [$clog2(RV16_NUM_FU)-1:0] w_gidx;
   rv16_wb_entry_t                 w_new, w_head;

   assign o_wb_valid = r_count != '0;
   assign w_pop      = o_wb_valid & i_wb_ready;
   // A full FIFO may still accept when the head leaves in the same cycle.
   assign w_en       = rst_n & ((r_count != (AW+1)'(DEPTH)) | w_pop);
   assign w_push     = |o_fu_ready;

   rv16_rr_arbiter #(.N(RV16_NUM_FU)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_req   (i_fu_valid),
      .i_en    (w_en),
      .o_grant (o_fu_ready),
      .o_idx   (w_gidx)
   );

   always_comb begin
      w_new        = '0;
      w_new.data   = i_fu_result[w_gidx*RV16_DATA +: RV16_DATA];
      w_new.rd     = i_fu_rd[w_gidx*RV16_REG_ADDR +: RV16_REG_ADDR];
      w_new.opcode = rv16_opcode_e'(RV16_OPCODE'(w_gidx));
`ifdef RV16_RESULT_FLAGS_EN
      w_new.zero   = ~|w_new.data;
      w_new.neg    = w_new.data[RV16_DATA-1];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= w_new;
            r_wr        <= r_wr + 1'b1;
         end
         if (w_pop) r_rd <= r_rd + 1'b1;
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

   assign w_head       = r_mem[r_rd];
   assign o_wb_data    = w_head.data;
   assign o_wb_rd      = w_head.rd;
   assign o_wb_opcode  = w_head.opcode;
   assign o_fifo_count = r_count;
`ifdef RV16_RESULT_FLAGS_EN
   assign o_wb_zero    = w_head.zero;
   assign o_wb_neg     = w_head.neg;
`endif
endmodule

// File: tb/tb_rv16_fu_result_collector.sv
// tb_rv16_fu_result_collector: scoreboard bench for the rv16 FU result collector
module tb_rv16_fu_result_collector;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [6:0]   fu_valid = '0;
   logic [111:0] fu_result = '0;
   logic [20:0]  fu_rd = '0;
   logic         wb_ready = 1'b0;
   logic [6:0]   o_fu_ready;
   logic         o_wb_valid;
   logic [15:0]  o_wb_data;
   logic [2:0]   o_wb_rd;
   logic [3:0]   o_wb_opcode;
   logic [2:0]   o_fifo_count;
`ifdef RV16_RESULT_FLAGS_EN
   logic         o_wb_zero, o_wb_neg;
`endif

   typedef struct packed {
      logic [15:0] d;
      logic [2:0]  rd;
      logic [3:0]  op;
   } ent_t;

   ent_t q[$];
   int   m_ptr = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   auto_drop = 1'b1;

   rv16_fu_result_collector dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_fu_valid   (fu_valid),
      .i_fu_result  (fu_result),
      .i_fu_rd      (fu_rd),
      .o_fu_ready   (o_fu_ready),
      .o_wb_valid   (o_wb_valid),
      .i_wb_ready   (wb_ready),
      .o_wb_data    (o_wb_data),
      .o_wb_rd      (o_wb_rd),
      .o_wb_opcode  (o_wb_opcode),
      .o_fifo_count (o_fifo_count)
`ifdef RV16_RESULT_FLAGS_EN
      ,
      .o_wb_zero    (o_wb_zero),
      .o_wb_neg     (o_wb_neg)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] exp_grant();
      logic [6:0] g = '0;
      bit allow = rst_n && (q.size() < 4 || (q.size() != 0 && wb_ready));
      if (allow)
         for (int k = 0; k < 7; k++)
            if (g == '0 && fu_valid[(m_ptr + k) % 7]) g[(m_ptr + k) % 7] = 1'b1;
      return g;
   endfunction

   // One clock of model + DUT: check at negedge, update model after the edge.
   task automatic cycle();
      logic [6:0] eg;
      int gi;
      bit pop;
      @(negedge clk);
      eg = exp_grant();
      n_chk++;
      if (o_fu_ready !== eg) begin
         n_fail++;
         $display("FAIL fu_ready: got %b expected %b", o_fu_ready, eg);
      end
      n_chk++;
      if (o_wb_valid !== (q.size() != 0)) begin
         n_fail++;
         $display("FAIL wb_valid: got %b expected %b", o_wb_valid, q.size() != 0);
      end
      n_chk++;
      if (o_fifo_count !== 3'(q.size())) begin
         n_fail++;
         $display("FAIL fifo_count: got %0d expected %0d", o_fifo_count, q.size());
      end
      if (q.size() != 0) begin
         n_chk++;
         if ({o_wb_data, o_wb_rd, o_wb_opcode} !== {q[0].d, q[0].rd, q[0].op}) begin
            n_fail++;
            $display("FAIL wb_head: got %h/%0d/%0d expected %h/%0d/%0d",
                     o_wb_data, o_wb_rd, o_wb_opcode, q[0].d, q[0].rd, q[0].op);
         end
`ifdef RV16_RESULT_FLAGS_EN
         n_chk++;
         if ({o_wb_zero, o_wb_neg} !== {q[0].d == 16'h0, q[0].d[15]}) begin
            n_fail++;
            $display("FAIL wb_flags: got %b%b expected %b%b", o_wb_zero, o_wb_neg,
                     q[0].d == 16'h0, q[0].d[15]);
         end
`endif
      end
      pop = q.size() != 0 && wb_ready && rst_n;
      @(posedge clk);
      #1;
      if (pop) void'(q.pop_front());
      gi = -1;
      for (int i = 0; i < 7; i++) if (eg[i]) gi = i;
      if (gi >= 0) begin
         q.push_back('{d: fu_result[gi*16 +: 16], rd: fu_rd[gi*3 +: 3], op: 4'(gi)});
         m_ptr = (gi + 1) % 7;
         if (auto_drop) fu_valid[gi] = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      fu_valid = '0;
      wb_ready = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      q.delete();
      m_ptr = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      fu_valid = 7'h7F;
      repeat (2) @(negedge clk);
      n_chk++;
      if (o_fu_ready !== 7'h00) begin
         n_fail++;
         $display("FAIL reset_fu_ready: got %b expected 0", o_fu_ready);
      end
      n_chk++;
      if (o_wb_valid !== 1'b0 || o_fifo_count !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_fifo: got valid %b count %0d expected 0/0", o_wb_valid, o_fifo_count);
      end
      n_chk++;
      if ({o_wb_data, o_wb_rd, o_wb_opcode} !== 23'h0) begin
         n_fail++;
         $display("FAIL reset_wb: got %h/%0d/%0d expected 0", o_wb_data, o_wb_rd, o_wb_opcode);
      end
      do_reset();
   endtask

   task automatic test_single();
      auto_drop = 1'b1;
      fu_result[2*16 +: 16] = 16'h0012;
      fu_rd[2*3 +: 3] = 3'd3;
      fu_valid = 7'b0000100;
      wb_ready = 1'b1;
      #1;
      n_chk++;
      if (o_fu_ready !== 7'b0000100) begin
         n_fail++;
         $display("FAIL single_grant: got %b expected 0000100", o_fu_ready);
      end
      cycle();
      n_chk++;
      if ({o_wb_valid, o_wb_data, o_wb_rd, o_wb_opcode} !== {1'b1, 16'h0012, 3'd3, 4'd2}) begin
         n_fail++;
         $display("FAIL single_wb: got %b/%h/%0d/%0d expected 1/0012/3/2",
                  o_wb_valid, o_wb_data, o_wb_rd, o_wb_opcode);
      end
      repeat (2) cycle();
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < 7; i++) begin
         fu_result[i*16 +: 16] = 16'h0100 + 16'(i);
         fu_rd[i*3 +: 3] = 3'(7 - i);
      end
      auto_drop = 1'b0;
      wb_ready = 1'b1;
      fu_valid = 7'h7F;
      for (int k = 0; k < 8; k++) begin
         #1;
         n_chk++;
         if (o_fu_ready !== (7'b1 << (k % 7))) begin
            n_fail++;
            $display("FAIL rr_order[%0d]: got %b expected %b", k, o_fu_ready, 7'b1 << (k % 7));
         end
         cycle();
      end
      fu_valid = '0;
      auto_drop = 1'b1;
      repeat (2) cycle();
   endtask

   task automatic test_full_backpressure();
      do_reset();
      for (int i = 0; i < 5; i++) fu_result[i*16 +: 16] = 16'hA000 + 16'(i);
      auto_drop = 1'b1;
      wb_ready = 1'b0;
      fu_valid = 7'b0011111;
      repeat (5) cycle();
      n_chk++;
      if (o_fifo_count !== 3'd4 || o_fu_ready !== 7'h00) begin
         n_fail++;
         $display("FAIL full_stall: got count %0d ready %b expected 4/0000000", o_fifo_count, o_fu_ready);
      end
      wb_ready = 1'b1;
      #1;
      n_chk++;
      if (o_fu_ready !== 7'b0010000) begin
         n_fail++;
         $display("FAIL full_pop_grant: got %b expected 0010000", o_fu_ready);
      end
      cycle();
      n_chk++;
      if (o_fifo_count !== 3'd4) begin
         n_fail++;
         $display("FAIL full_pushpop_count: got %0d expected 4", o_fifo_count);
      end
      repeat (5) cycle();
   endtask

   task automatic test_wrap();
      auto_drop = 1'b0;
      wb_ready = 1'b1;
      fu_rd[3*3 +: 3] = 3'd5;
      fu_valid = 7'b0001000;
      for (int k = 1; k <= 10; k++) begin
         fu_result[3*16 +: 16] = 16'(k);
         cycle();
      end
      fu_valid = '0;
      auto_drop = 1'b1;
      repeat (2) cycle();
   endtask

   task automatic test_reset_mid();
      auto_drop = 1'b1;
      wb_ready = 1'b0;
      fu_valid = 7'b0000111;
      repeat (3) cycle();
      n_chk++;
      if (o_fifo_count !== 3'd3) begin
         n_fail++;
         $display("FAIL mid_fill: got %0d expected 3", o_fifo_count);
      end
      rst_n = 1'b0;
      q.delete();
      m_ptr = 0;
      @(negedge clk);
      n_chk++;
      if (o_wb_valid !== 1'b0 || o_fifo_count !== 3'd0) begin
         n_fail++;
         $display("FAIL mid_reset: got valid %b count %0d expected 0/0", o_wb_valid, o_fifo_count);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) cycle();
   endtask

`ifdef RV16_RESULT_FLAGS_EN
   task automatic test_flags();
      do_reset();
      auto_drop = 1'b1;
      fu_result[0 +: 16] = 16'h0000;
      fu_result[16 +: 16] = 16'h8001;
      fu_valid = 7'b0000011;
      repeat (2) cycle();
      n_chk++;
      if ({o_wb_zero, o_wb_neg} !== 2'b10) begin
         n_fail++;
         $display("FAIL flags_zero: got %b%b expected 10", o_wb_zero, o_wb_neg);
      end
      wb_ready = 1'b1;
      cycle();
      n_chk++;
      if ({o_wb_zero, o_wb_neg} !== 2'b01) begin
         n_fail++;
         $display("FAIL flags_neg: got %b%b expected 01", o_wb_zero, o_wb_neg);
      end
      repeat (2) cycle();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_full_backpressure();
      test_wrap();
      test_reset_mid();
`ifdef RV16_RESULT_FLAGS_EN
      test_flags();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
